uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: schedules telemetry packets and single ack bytes onto one
// UART transmitter. Telemetry is a framed packet (AA 55 + 6 payload bytes);
// acks have priority but are only inserted between packets.
// Optional feature: define TX_SCHED_CHKSUM_EN to append a ninth byte holding
// the complemented modulo-256 sum of the six payload bytes.
module uart_tx_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlm_req,
  input  logic [47:0] tlm_data,
  input  logic        ack_req,
  input  logic [7:0]  ack_byte,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        tlm_busy,
  output logic        tlm_sent,
  output logic        tlm_drop,
  output logic        ack_sent,
  output logic        ack_ovr
);

`ifdef TX_SCHED_CHKSUM_EN
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = 4'd8;
`else
  localparam int CW = 3;
  localparam logic [CW-1:0] LAST = 3'd7;
`endif

  typedef enum logic [1:0] {IDLE, SEND, SKIP, WAIT} state_t;

  state_t          state, state_next;
  logic [47:0]     shadow;
  logic [7:0]      ack_hold;
  logic            ack_pend;
  logic            cur_tlm;
  logic [CW-1:0]   cnt;
  logic            start_ack, start_tlm, advance, pkt_done, ack_done;

  // Byte idx of the packet built from payload d.
  function automatic logic [7:0] pkt_byte(input logic [CW-1:0] idx, input logic [47:0] d);
`ifdef TX_SCHED_CHKSUM_EN
    logic [7:0] sum;
    sum = d[47:40] + d[39:32] + d[31:24] + d[23:16] + d[15:8] + d[7:0];
`endif
    case (int'(idx))
      0:       pkt_byte = 8'hAA;
      1:       pkt_byte = 8'h55;
      2:       pkt_byte = d[47:40];
      3:       pkt_byte = d[39:32];
      4:       pkt_byte = d[31:24];
      5:       pkt_byte = d[23:16];
      6:       pkt_byte = d[15:8];
      7:       pkt_byte = d[7:0];
`ifdef TX_SCHED_CHKSUM_EN
      8:       pkt_byte = ~sum;
`endif
      default: pkt_byte = 8'h00;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode: arbitrate only from IDLE, ack before telemetry, and
  // never leave a telemetry packet until its last byte has completed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_next = state;
    start_ack  = 1'b0;
    start_tlm  = 1'b0;
    advance    = 1'b0;
    pkt_done   = 1'b0;
    ack_done   = 1'b0;
    case (state)
      IDLE: begin
        if (ack_pend) begin
          start_ack  = 1'b1;
          state_next = SEND;
        end else if (tlm_busy) begin
          start_tlm  = 1'b1;
          state_next = SEND;
        end
      end
      SEND: state_next = SKIP;
      // tx_done still shows the previous byte here; trmt clears it this cycle.
      SKIP: state_next = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (cur_tlm && cnt != LAST) begin
            advance    = 1'b1;
            state_next = SEND;
          end else begin
            state_next = IDLE;
            pkt_done   = cur_tlm;
            ack_done   = !cur_tlm;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching, byte selection and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      trmt     <= 1'b0;
      tx_data  <= 8'h00;
      tlm_busy <= 1'b0;
      tlm_sent <= 1'b0;
      tlm_drop <= 1'b0;
      ack_sent <= 1'b0;
      ack_ovr  <= 1'b0;
      shadow   <= '0;
      ack_hold <= 8'h00;
      ack_pend <= 1'b0;
      cur_tlm  <= 1'b0;
      cnt      <= '0;
    end else begin
      trmt     <= (state_next == SEND);
      tlm_sent <= pkt_done;
      ack_sent <= ack_done;
      tlm_drop <= tlm_req && tlm_busy;
      // An ack being launched this cycle is no longer pending, so a new one
      // arriving now is not an overwrite.
      ack_ovr  <= ack_req && ack_pend && !start_ack;

      if (ack_req) begin
        ack_pend <= 1'b1;
        ack_hold <= ack_byte;
      end else if (start_ack) begin
        ack_pend <= 1'b0;
      end

      // Busy drops together with tlm_sent, so a request in that cycle is taken.
      if (tlm_req && !tlm_busy) begin
        shadow   <= tlm_data;
        tlm_busy <= 1'b1;
      end else if (pkt_done) begin
        tlm_busy <= 1'b0;
      end

      if (start_ack) begin
        tx_data <= ack_hold;
        cur_tlm <= 1'b0;
      end else if (start_tlm) begin
        tx_data <= pkt_byte('0, shadow);
        cur_tlm <= 1'b1;
        cnt     <= '0;
      end else if (advance) begin
        tx_data <= pkt_byte(cnt + 1'b1, shadow);
        cnt     <= cnt + 1'b1;
      end else if (pkt_done) begin
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched. A UART_tx model consumes bytes on
// trmt and raises tx_done a few cycles later; expected bytes are queued when
// requests are driven and compared as each trmt is observed.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tlm_req = 1'b0;
  logic [47:0] tlm_data = '0;
  logic        ack_req = 1'b0;
  logic [7:0]  ack_byte = 8'h00;
  logic        tx_done = 1'b1;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tlm_busy, tlm_sent, tlm_drop, ack_sent, ack_ovr;

  int total = 0;
  int bad   = 0;
  int trmt_n = 0, sent_n = 0, ack_n = 0, drop_n = 0, ovr_n = 0;
  int byte_time = 0;
  logic [7:0] exp_q[$];

  uart_tx_sched dut (
    .clk(clk), .rst(rst), .tlm_req(tlm_req), .tlm_data(tlm_data),
    .ack_req(ack_req), .ack_byte(ack_byte), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data), .tlm_busy(tlm_busy), .tlm_sent(tlm_sent),
    .tlm_drop(tlm_drop), .ack_sent(ack_sent), .ack_ovr(ack_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void push_pkt(input logic [47:0] d);
    logic [7:0] sum;
    sum = 8'h00;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(d[47-8*i -: 8]);
      sum = sum + d[47-8*i -: 8];
    end
`ifdef TX_SCHED_CHKSUM_EN
    exp_q.push_back(~sum);
`endif
  endfunction

  function automatic int cnt_of(input int k);
    case (k)
      0:       return trmt_n;
      1:       return sent_n;
      default: return ack_n;
    endcase
  endfunction

  // UART_tx model plus output monitor, on the falling edge.
  always @(negedge clk) begin
    if (trmt) begin
      trmt_n++;
      if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
      else                   check("tx_byte", tx_data, exp_q.pop_front());
      tx_done   = 1'b0;
      byte_time = 4;
    end else if (byte_time > 0) begin
      byte_time--;
      if (byte_time == 0) tx_done = 1'b1;
    end
    if (tlm_sent) sent_n++;
    if (ack_sent) ack_n++;
    if (tlm_drop) drop_n++;
    if (ack_ovr)  ovr_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tlm(input logic [47:0] d);
    @(posedge clk); #1;
    tlm_req = 1'b1; tlm_data = d;
    @(posedge clk); #1;
    tlm_req = 1'b0;
  endtask

  task automatic pulse_ack(input logic [7:0] b);
    @(posedge clk); #1;
    ack_req = 1'b1; ack_byte = b;
    @(posedge clk); #1;
    ack_req = 1'b0;
  endtask

  // Wait (bounded) until counter k reaches target.
  task automatic wait_cnt(input string tag, input int k, input int target);
    for (int i = 0; i < 400 && cnt_of(k) < target; i++) begin
      @(negedge clk); #1;
    end
    check(tag, cnt_of(k) >= target, 1);
  endtask

  localparam logic [47:0] D1 = 48'h0102030405AB;
  localparam logic [47:0] D2 = 48'hDEADBEEF0042;
  localparam logic [47:0] D3 = 48'h1020304050F0;
  localparam logic [47:0] D4 = 48'hC0FFEE123456;
  localparam logic [47:0] D5 = 48'h999999999999;
  localparam logic [47:0] D6 = 48'h0F1E2D3C4B5A;
  localparam logic [47:0] D7 = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] D8 = 48'h000000000000;

`ifdef TX_SCHED_CHKSUM_EN
  localparam int PKT = 9;
`else
  localparam int PKT = 8;
`endif

  initial begin
    int t0, s0, a0;

    // Reset state, with a request present in the reset cycle.
    tick(2);
    tlm_req = 1'b1; ack_req = 1'b1;
    tick(1);
    tlm_req = 1'b0; ack_req = 1'b0;
    @(negedge clk);
    check("rst_trmt", trmt, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", tlm_busy, 0);
    check("rst_pulses", {tlm_sent, tlm_drop, ack_sent, ack_ovr}, 4'b0000);
    rst = 1'b0;
    tick(6);
    check("rst_req_ignored", {trmt_n, tlm_busy}, 0);

    // Single packet: latency, byte order, one tlm_sent, busy clears with it.
    t0 = trmt_n;
    pulse_tlm(D1);
    push_pkt(D1);
    @(negedge clk);
    check("busy_set", tlm_busy, 1);
    check("lat_cycle1", trmt, 0);
    @(negedge clk);
    check("lat_cycle2", trmt, 1);
    wait_cnt("pkt1_done", 1, 1);
    check("busy_clr_with_sent", tlm_busy, 0);
    check("pkt1_trmts", trmt_n - t0, PKT);
    check("pkt1_sent", sent_n, 1);
    check("pkt1_q_empty", exp_q.size(), 0);

    // Ack and telemetry together from IDLE: ack goes first.
    t0 = trmt_n;
    @(posedge clk); #1;
    tlm_req = 1'b1; tlm_data = D2; ack_req = 1'b1; ack_byte = 8'h3C;
    exp_q.push_back(8'h3C);
    push_pkt(D2);
    @(posedge clk); #1;
    tlm_req = 1'b0; ack_req = 1'b0;
    wait_cnt("pkt2_done", 1, 2);
    check("pkt2_acks", ack_n, 1);
    check("pkt2_trmts", trmt_n - t0, PKT + 1);

    // Ack during byte 3 waits for the end of the packet.
    pulse_tlm(D3);
    push_pkt(D3);
    t0 = trmt_n;
    wait_cnt("pkt3_byte3", 0, t0 + 3);
    pulse_ack(8'h11);
    exp_q.push_back(8'h11);
    wait_cnt("pkt3_ack_done", 2, 2);
    check("pkt3_sent_before_ack", sent_n, 3);
    check("pkt3_q_empty", exp_q.size(), 0);

    // Request while busy is dropped; shadow keeps the first payload.
    pulse_tlm(D4);
    push_pkt(D4);
    tick(2);
    pulse_tlm(D5);
    @(negedge clk);
    check("drop_hi", tlm_drop, 1);
    @(negedge clk);
    check("drop_lo", tlm_drop, 0);
    wait_cnt("pkt4_done", 1, 4);
    check("drop_count", drop_n, 1);
    tick(20);
    check("drop_no_extra_pkt", exp_q.size() + sent_n, 4);

    // Two acks while telemetry is in flight: overwrite, only the last is sent.
    a0 = ack_n;
    pulse_tlm(D6);
    push_pkt(D6);
    tick(3);
    pulse_ack(8'h22);
    tick(2);
    pulse_ack(8'h33);
    exp_q.push_back(8'h33);
    wait_cnt("ovr_ack_done", 2, a0 + 1);
    tick(30);
    check("ovr_count", ovr_n, 1);
    check("ovr_one_ack", ack_n - a0, 1);

    // New request in the tlm_sent cycle is accepted.
    pulse_tlm(D7);
    push_pkt(D7);
    for (int i = 0; i < 400 && !tlm_sent; i++) begin
      @(negedge clk); #1;
    end
    check("b2b_saw_sent", tlm_sent, 1);
    tlm_req = 1'b1; tlm_data = D8;
    push_pkt(D8);
    @(posedge clk); #1;
    tlm_req = 1'b0;
    @(negedge clk);
    check("b2b_no_drop", tlm_drop, 0);
    check("b2b_busy", tlm_busy, 1);
    wait_cnt("b2b_done", 1, 7);

    // Reset during byte 5 abandons the packet and the pending ack.
    pulse_tlm(D1);
    push_pkt(D1);
    t0 = trmt_n;
    wait_cnt("rst_byte5", 0, t0 + 5);
    pulse_ack(8'h77);
    @(posedge clk); #1;
    rst = 1'b1; tlm_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tlm_req = 1'b0;
    exp_q.delete();
    s0 = sent_n; a0 = ack_n; t0 = trmt_n;
    @(negedge clk);
    check("mid_rst_busy", tlm_busy, 0);
    check("mid_rst_trmt", trmt, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_sent", tlm_sent, 0);
    tick(60);
    check("mid_rst_no_sent", sent_n - s0, 0);
    check("mid_rst_no_ack", ack_n - a0, 0);
    check("mid_rst_idle", trmt_n - t0, 0);

    // Recovery after reset.
    pulse_tlm(D1);
    push_pkt(D1);
    wait_cnt("recover_done", 1, s0 + 1);
    check("recover_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
